// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: fetch sequencer for the instruction ROM.
//   Owns the PC, drives the ROM byte address and registers each returned word
//   into a one-entry output stage handshaked (valid/ready) toward decode.
//   Branch/jump redirects flush the stage. A misaligned redirect sets a
//   sticky error. Fetching at or beyond the end of the ROM halts the sequencer.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             leave IDLE/HALT, restart at RESET_PC
//   redirect_valid/pc taken branch/jump target (RUN only)
//   imem_pc/rdata     ROM byte address out, combinational word back
//   inst_valid/ready  output stage handshake
//   inst_out/inst_pc  fetched word and the byte address it came from
//   halted            sequencer is in HALT
//   align_err         sticky misaligned-redirect flag
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        halted,
  output logic        align_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        align_err_q, align_err_d;

  // The stage can take a new word when empty or being drained this cycle.
  logic slot;
  logic end_hit;
  assign slot    = !inst_valid_q || inst_ready;
  assign end_hit = {2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a redirect beats the end-of-program halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALT: if (start) state_d = S_RUN;
      S_RUN:          if (!redirect_valid && slot && end_hit) state_d = S_HALT;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    pc_d         = pc_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    align_err_d  = align_err_q;
    halted       = (state_q == S_HALT);
    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          // Flush: the pending word (if any) is dropped, target fetched next cycle.
          pc_d         = {redirect_pc[31:2], 2'b00};
          inst_valid_d = 1'b0;
          if (redirect_pc[1:0] != 2'b00) align_err_d = 1'b1;
        end else if (slot) begin
          if (end_hit) begin
            // Slot implies the stage is empty or draining now, so it ends empty.
            inst_valid_d = 1'b0;
          end else begin
            inst_out_d   = imem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
          end
        end
      end
      default: begin
        if (start) begin
          pc_d         = RESET_PC;
          inst_valid_d = 1'b0;
        end else if (inst_ready) begin
          // A word left over from the halting cycle drains normally.
          inst_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_out_q   <= 32'h0;
      inst_pc_q    <= 32'h0;
      align_err_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      align_err_q  <= align_err_d;
    end
  end

  assign imem_pc    = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_pc    = inst_pc_q;
  assign align_err  = align_err_q;

endmodule
